instruction_fetch_sequencer: RTL and testbench
==============================================

// Module: instruction_fetch_sequencer
// PURPOSE
//  Hardware program sequencer for the core. Walks program memory from address 0, fetches each
//  instruction and issues it over the core's start/busy handshake. Drains the core after the
//  last issue, then reports done with cycle and issue counts. Sits between program RAM and core.
// PARAMETERS
//  INSTRUCTION_WIDTH  `INSTRUCTION_WIDTH  instruction word width
//  ADDR_WIDTH         10                  program memory address width (max 1024 instructions)
//  COUNT_WIDTH        32                  width of cycleCount
// PORTS
//  clk             in   1                   single clock, all state on posedge
//  reset           in   1                   asynchronous, active-low (0 = reset)
//  run             in   1                   start program; sampled in IDLE/DONE only
//  abort           in   1                   synchronous abort to IDLE, any state
//  programLength   in   ADDR_WIDTH+1        instruction count, latched on run accept
//  memAddr         out  ADDR_WIDTH          program memory read address
//  memReadEn       out  1                   memory read enable; 1-cycle synchronous read latency
//  memData         in   INSTRUCTION_WIDTH   read data, valid the cycle after memReadEn=1
//  instructionOut  out  INSTRUCTION_WIDTH   registered instruction presented to core
//  start           out  1                   instruction valid; core accepts on posedge with start=1
//  coreBusy        in   1                   core busy; no issue while high
//  done            out  1                   program complete, held until next run or abort
//  cycleCount      out  COUNT_WIDTH         active cycles of the current/last run
//  issueCount      out  ADDR_WIDTH+1        instructions accepted by the core
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; all outputs 0; pc=0; latched length=0.
//  States: IDLE, FETCH, LOAD, ISSUE, DRAIN, DONE. Internal pc is ADDR_WIDTH+1 bits; memAddr=pc[ADDR_WIDTH-1:0].
//  IDLE/DONE: run=1 -> latch len=min(programLength, 2^ADDR_WIDTH), clear cycleCount, issueCount,
//    done, pc=0; len==0 -> DONE with done=1 next cycle, no reads; else -> FETCH.
//  FETCH: memReadEn=1, memAddr=pc; -> LOAD.
//  LOAD: memReadEn=0; instructionOut <= memData at end of cycle; -> ISSUE.
//  ISSUE: start = ~coreBusy (combinational on coreBusy; instructionOut stable).
//    Edge with start=1: issueCount++, pc++; if pc+1==len -> DRAIN else -> FETCH.
//    Edge with coreBusy=1: stay in ISSUE.
//  DRAIN: min 1 cycle; exit to DONE on first edge in DRAIN with coreBusy=0; done=1 from DONE entry.
//  Minimum cost per instruction: 3 cycles (FETCH, LOAD, ISSUE); no prefetch.
//  cycleCount: +1 every cycle in FETCH/LOAD/ISSUE/DRAIN; saturates at all ones; holds in IDLE/DONE.
//  start and memReadEn are 0 in IDLE, DONE, DRAIN.
//  abort=1: -> IDLE next edge; start, memReadEn, done = 0; counters hold values. abort beats run.
//  run while in FETCH/LOAD/ISSUE/DRAIN: ignored.
//  reset mid-operation: immediate return to reset values; partially issued program is not resumed.
//  len==2^ADDR_WIDTH: last memAddr = all ones; pc reaching len ends program, no wrap to address 0.
// TESTING
//  1 reset=0 asserted mid-ISSUE -> same instant: start=0, memReadEn=0, done=0, counters 0; IDLE after release.
//  2 mem[0..2]=A,B,C, programLength=3, coreBusy=0, run pulse -> start on A,B,C in order,
//    memAddr 0,1,2; done=1; cycleCount=10; issueCount=3.
//  3 as 2, coreBusy=1 for 4 cycles in ISSUE of B -> start=0 those cycles, instructionOut=B held,
//    cycleCount=14, issueCount=3.
//  4 programLength=0, run -> done=1 next cycle, memReadEn never 1, cycleCount=0, issueCount=0.
//  5 programLength=3, abort during LOAD of B -> IDLE next edge, B never issued, issueCount=1;
//    run again -> restarts at memAddr 0, issueCount ends 3.
//  6 programLength=1024 (ADDR_WIDTH=10), coreBusy=0 -> final memAddr=1023, issueCount=1024,
//    cycleCount=3073, no read of address 0 after first.

Source files
------------

// File: rtl/instruction_fetch_sequencer_if.sv
// ============================================================================
// Module  : instruction_fetch_sequencer_if
// Brief   : Program-memory read bus and core start/busy handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_sequencer_if #(
   parameter int INSTRUCTION_WIDTH = 32,
   parameter int ADDR_WIDTH        = 10
);
   logic [ADDR_WIDTH-1:0]        memAddr;
   logic                         memReadEn;
   logic [INSTRUCTION_WIDTH-1:0] memData;
   logic [INSTRUCTION_WIDTH-1:0] instructionOut;
   logic                         start;
   logic                         coreBusy;

   modport master (
      output memAddr, memReadEn, instructionOut, start,
      input  memData, coreBusy
   );

   modport slave (
      input  memAddr, memReadEn, instructionOut, start,
      output memData, coreBusy
   );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_sequencer.sv
// ============================================================================
// Module  : instruction_fetch_sequencer
// Brief   : Walks program memory, issues each instruction to the core, drains, reports done.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_sequencer #(
   parameter int INSTRUCTION_WIDTH = 32,
   parameter int ADDR_WIDTH        = 10,
   parameter int COUNT_WIDTH       = 32
) (
   input  wire logic                   clk,
   input  wire logic                   reset,
   input  wire logic                   run,
   input  wire logic                   abort,
   input  wire logic [ADDR_WIDTH:0]    programLength,
   instruction_fetch_sequencer_if.master bus,
   output logic                        done,
   output logic [COUNT_WIDTH-1:0]      cycleCount,
   output logic [ADDR_WIDTH:0]         issueCount
);

   localparam logic [2:0] c_idle  = 3'd0;
   localparam logic [2:0] c_fetch = 3'd1;
   localparam logic [2:0] c_load  = 3'd2;
   localparam logic [2:0] c_issue = 3'd3;
   localparam logic [2:0] c_drain = 3'd4;
   localparam logic [2:0] c_done  = 3'd5;

   localparam logic [ADDR_WIDTH:0] c_max_len = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] c_one     = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [2:0]                   r_state;
   logic [2:0]                   w_next_state;
   logic [ADDR_WIDTH:0]          r_pc;
   logic [ADDR_WIDTH:0]          r_len;
   logic [INSTRUCTION_WIDTH-1:0] r_instr;
   logic [COUNT_WIDTH-1:0]       r_cycle;
   logic [ADDR_WIDTH:0]          r_issue;

   logic [ADDR_WIDTH:0]          w_len_clip;
   logic                         w_idle_like;
   logic                         w_active;
   logic                         w_accept;
   logic                         w_last;

   assign w_len_clip  = (programLength > c_max_len) ? c_max_len : programLength;
   assign w_idle_like = (r_state == c_idle) || (r_state == c_done);
   assign w_active    = (r_state == c_fetch) || (r_state == c_load) ||
                        (r_state == c_issue) || (r_state == c_drain);
   assign w_accept    = (r_state == c_issue) && !bus.coreBusy;
   // pc is one bit wider than the address so a full 2^ADDR_WIDTH program ends instead of wrapping
   assign w_last      = ((r_pc + c_one) == r_len);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (abort) begin
         w_next_state = c_idle;
      end else begin
         case (r_state)
            c_idle, c_done: begin
               if (run) begin
                  w_next_state = (w_len_clip == '0) ? c_done : c_fetch;
               end
            end
            c_fetch: w_next_state = c_load;
            c_load:  w_next_state = c_issue;
            c_issue: begin
               if (!bus.coreBusy) begin
                  w_next_state = w_last ? c_drain : c_fetch;
               end
            end
            c_drain: begin
               if (!bus.coreBusy) begin
                  w_next_state = c_done;
               end
            end
            default: w_next_state = c_idle;
         endcase
      end
   end

   always_comb begin
      bus.memReadEn = 1'b0;
      bus.start     = 1'b0;
      done          = 1'b0;
      case (r_state)
         c_fetch: bus.memReadEn = 1'b1;
         c_issue: bus.start     = !bus.coreBusy;
         c_done:  done          = 1'b1;
         default: ;
      endcase
   end

   // Abort freezes every counter and pointer; only the state returns to idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc    <= '0;
         r_len   <= '0;
         r_instr <= '0;
         r_cycle <= '0;
         r_issue <= '0;
      end else if (!abort) begin
         if (w_idle_like && run) begin
            r_len   <= w_len_clip;
            r_pc    <= '0;
            r_cycle <= '0;
            r_issue <= '0;
         end
         if (w_active && (r_cycle != '1)) begin
            r_cycle <= r_cycle + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
         end
         if (r_state == c_load) begin
            r_instr <= bus.memData;
         end
         if (w_accept) begin
            r_pc    <= r_pc + c_one;
            r_issue <= r_issue + c_one;
         end
      end
   end

   assign bus.memAddr        = r_pc[ADDR_WIDTH-1:0];
   assign bus.instructionOut = r_instr;
   assign cycleCount         = r_cycle;
   assign issueCount         = r_issue;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_sequencer.sv
// ============================================================================
// Module  : tb_instruction_fetch_sequencer
// Brief   : Scoreboard bench for instruction_fetch_sequencer with program RAM and core model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_sequencer;

   localparam int c_iw = 32;
   localparam int c_aw = 10;
   localparam int c_cw = 32;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            run = 1'b0;
   logic            abort = 1'b0;
   logic [c_aw:0]   programLength = '0;
   logic            done;
   logic [c_cw-1:0] cycleCount;
   logic [c_aw:0]   issueCount;

   instruction_fetch_sequencer_if #(.INSTRUCTION_WIDTH(c_iw), .ADDR_WIDTH(c_aw)) bus ();

   instruction_fetch_sequencer #(
      .INSTRUCTION_WIDTH(c_iw), .ADDR_WIDTH(c_aw), .COUNT_WIDTH(c_cw)
   ) dut (
      .clk(clk), .reset(reset), .run(run), .abort(abort),
      .programLength(programLength), .bus(bus.master),
      .done(done), .cycleCount(cycleCount), .issueCount(issueCount)
   );

   always #5 clk = ~clk;

   logic [c_iw-1:0] mem [0:1023];
   logic [c_iw-1:0] instr_q [$];
   logic [c_aw-1:0] addr_q [$];
   int              n_tests = 0;
   int              n_fail  = 0;
   int              rd_count = 0;
   logic            stall_arm = 1'b0;
   int              stall_left = 0;
   logic            prev_rd = 1'b0;
   logic [c_aw-1:0] prev_addr = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always_ff @(posedge clk) begin
      if (bus.memReadEn) bus.memData <= mem[bus.memAddr];
   end

   // Core model: stalls 4 ISSUE edges on the second instruction when armed.
   initial bus.coreBusy = 1'b0;
   always @(posedge clk) begin
      #1;
      if (stall_left > 0) begin
         stall_left--;
         if (stall_left == 0) bus.coreBusy = 1'b0;
      end else if (stall_arm && prev_rd && prev_addr == 10'd1) begin
         bus.coreBusy = 1'b1;
         stall_left   = 5;
      end
      prev_rd   = bus.memReadEn;
      prev_addr = bus.memAddr;
   end

   always @(negedge clk) begin
      if (reset) begin
         if (bus.memReadEn) begin
            rd_count++;
            chk("addr_expected", 64'(addr_q.size() != 0), 64'd1);
            if (addr_q.size() != 0) chk("memAddr", 64'(bus.memAddr), 64'(addr_q.pop_front()));
         end
         if (bus.start) begin
            chk("issue_expected", 64'(instr_q.size() != 0), 64'd1);
            if (instr_q.size() != 0) chk("instructionOut", 64'(bus.instructionOut), 64'(instr_q.pop_front()));
         end
         if (bus.coreBusy) chk("start_while_busy", 64'(bus.start), 64'd0);
         if (stall_left >= 1 && stall_left <= 4) chk("held_instr", 64'(bus.instructionOut), 64'(mem[1]));
      end
   end

   task automatic wait_done(input int max_cyc);
      for (int i = 0; i < max_cyc && !done; i++) @(negedge clk);
      chk("done_timeout", 64'(done), 64'd1);
   endtask

   task automatic run_prog(input int len, input int stall, input int max_cyc);
      int eff;
      eff = (len > 1024) ? 1024 : len;
      for (int i = 0; i < eff; i++) begin
         instr_q.push_back(mem[i]);
         addr_q.push_back(c_aw'(i));
      end
      @(negedge clk);
      programLength = (c_aw+1)'(len);
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      chk("done_after_run", 64'(done), 64'(eff == 0));
      wait_done(max_cyc);
      chk("cycleCount", 64'(cycleCount), (eff == 0) ? 64'd0 : 64'(3 * eff + 1 + stall));
      chk("issueCount", 64'(issueCount), 64'(eff));
      chk("instr_q_empty", 64'(instr_q.size()), 64'd0);
      chk("addr_q_empty", 64'(addr_q.size()), 64'd0);
   endtask

   initial begin
      int rd_before;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      mem[0] = 32'hA000_000A;
      mem[1] = 32'hB000_000B;
      mem[2] = 32'hC000_000C;
      bus.memData = '0;

      #1;
      chk("rst_start", 64'(bus.start), 64'd0);
      chk("rst_memReadEn", 64'(bus.memReadEn), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_memAddr", 64'(bus.memAddr), 64'd0);
      chk("rst_instructionOut", 64'(bus.instructionOut), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Three-instruction program, no stalls
      run_prog(3, 0, 50);

      // Same program with a 4-cycle stall while B is offered
      stall_arm = 1'b1;
      run_prog(3, 4, 60);
      stall_arm = 1'b0;

      // Empty program: immediate done, no reads
      rd_before = rd_count;
      run_prog(0, 0, 5);
      chk("len0_no_reads", 64'(rd_count - rd_before), 64'd0);

      // Abort during LOAD of B
      instr_q.push_back(mem[0]); instr_q.push_back(mem[1]); instr_q.push_back(mem[2]);
      addr_q.push_back(10'd0); addr_q.push_back(10'd1); addr_q.push_back(10'd2);
      @(negedge clk);
      programLength = 11'd3;
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      for (int i = 0; i < 20 && !(bus.memReadEn && bus.memAddr == 10'd1); i++) @(negedge clk);
      chk("fetch_b_seen", 64'(bus.memReadEn && bus.memAddr == 10'd1), 64'd1);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      instr_q.delete();
      addr_q.delete();
      chk("abort_issueCount", 64'(issueCount), 64'd1);
      chk("abort_cycleCount", 64'(cycleCount), 64'd4);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_start", 64'(bus.start), 64'd0);
      chk("abort_memReadEn", 64'(bus.memReadEn), 64'd0);
      repeat (3) @(negedge clk);
      chk("abort_stays_idle", 64'(bus.memReadEn | bus.start | done), 64'd0);
      run_prog(3, 0, 50);

      // Reset asserted while an instruction is offered
      @(negedge clk);
      programLength = 11'd3;
      instr_q.push_back(mem[0]); addr_q.push_back(10'd0);
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      for (int i = 0; i < 20 && !bus.start; i++) @(negedge clk);
      chk("start_seen", 64'(bus.start), 64'd1);
      #1 reset = 1'b0;
      #1;
      chk("rstmid_start", 64'(bus.start), 64'd0);
      chk("rstmid_memReadEn", 64'(bus.memReadEn), 64'd0);
      chk("rstmid_done", 64'(done), 64'd0);
      chk("rstmid_cycleCount", 64'(cycleCount), 64'd0);
      chk("rstmid_issueCount", 64'(issueCount), 64'd0);
      instr_q.delete();
      addr_q.delete();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rstmid_idle", 64'(bus.memReadEn | bus.start | done), 64'd0);

      // Full-size program, then an over-length request clipped to memory size
      run_prog(1024, 0, 3200);
      run_prog(1500, 0, 3200);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
